// File: rtl/net_engine_pkg.sv
// Shared types and constants for the convolution engine datapath.
package net_engine_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int KERNAL_SIZE   = 3;
    localparam int MAX_IMG_WIDTH = 64;
    localparam int DIM_BITS      = 8;
    localparam int LB_ADDR_W     = $clog2(MAX_IMG_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } win_state_t;

    localparam int WIN_1 = 0;
    localparam int WIN_2 = 1;
    localparam int WIN_3 = 2;
    localparam int WIN_4 = 3;
    localparam int WIN_5 = 4;
    localparam int WIN_6 = 5;
    localparam int WIN_7 = 6;
    localparam int WIN_8 = 7;
    localparam int WIN_9 = 8;
    localparam int WIN_N = KERNAL_SIZE * KERNAL_SIZE;

    localparam logic [DIM_BITS-1:0] MIN_DIM = DIM_BITS'(KERNAL_SIZE);
    localparam logic [DIM_BITS-1:0] MAX_W_D = DIM_BITS'(MAX_IMG_WIDTH);

    function automatic logic dims_ok(input logic [DIM_BITS-1:0] w,
                                     input logic [DIM_BITS-1:0] h);
        return (w >= MIN_DIM) && (w <= MAX_W_D) && (h >= MIN_DIM);
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Single-port line buffer: async read of the write address returns the old word.
module conv_line_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  C_IN_CLK,
    input  logic                  C_IN_WE,
    input  logic [ADDR_W-1:0]     D_IN_ADDR,
    input  logic [DATA_WIDTH-1:0] D_IN_WDATA,
    output logic [DATA_WIDTH-1:0] D_OUT_RDATA
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge C_IN_CLK) begin
        if (C_IN_WE)
            mem[D_IN_ADDR] <= D_IN_WDATA;
    end

    assign D_OUT_RDATA = mem[D_IN_ADDR];

endmodule

// File: rtl/conv_window_gen.sv
// Streams a row-major image through two line buffers and emits every
// fully-populated 3x3 window, one per accepted pixel once row>=2 and col>=2.
module conv_window_gen
    import net_engine_pkg::*;
(
    input  logic                  C_IN_CLK,
    input  logic                  C_IN_RST,
    input  logic                  C_IN_START,
    input  logic [DIM_BITS-1:0]   D_IN_IMG_WIDTH,
    input  logic [DIM_BITS-1:0]   D_IN_IMG_HEIGHT,
    input  logic                  C_IN_DATA_VALID,
    input  logic [DATA_WIDTH-1:0] D_IN_DATA,
    output logic                  C_OUT_DATA_VALID,
    output logic [DATA_WIDTH-1:0] D_OUT_WIN_1,
    output logic [DATA_WIDTH-1:0] D_OUT_WIN_2,
    output logic [DATA_WIDTH-1:0] D_OUT_WIN_3,
    output logic [DATA_WIDTH-1:0] D_OUT_WIN_4,
    output logic [DATA_WIDTH-1:0] D_OUT_WIN_5,
    output logic [DATA_WIDTH-1:0] D_OUT_WIN_6,
    output logic [DATA_WIDTH-1:0] D_OUT_WIN_7,
    output logic [DATA_WIDTH-1:0] D_OUT_WIN_8,
    output logic [DATA_WIDTH-1:0] D_OUT_WIN_9,
    output logic                  C_OUT_BUSY,
    output logic                  C_OUT_FRAME_DONE,
    output logic                  C_OUT_CFG_ERR
);

    win_state_t state_q, state_d;

    logic [DIM_BITS-1:0]   w_q, h_q;
    logic [DIM_BITS-1:0]   row_q, col_q;
    logic                  valid_q, err_q;
    logic [DATA_WIDTH-1:0] win_q [WIN_N];
    logic [DATA_WIDTH-1:0] lba_rd, lbb_rd;

    logic start_ok, accept, last_col, last_row, last_pix;

    assign start_ok = dims_ok(D_IN_IMG_WIDTH, D_IN_IMG_HEIGHT);
    assign accept   = (state_q == ST_RUN) && C_IN_DATA_VALID && !C_IN_START;
    assign last_col = (col_q == w_q - 1'b1);
    assign last_row = (row_q == h_q - 1'b1);
    assign last_pix = last_col && last_row;

    conv_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_IMG_WIDTH),
        .ADDR_W     (LB_ADDR_W)
    ) u_lb_a (
        .C_IN_CLK    (C_IN_CLK),
        .C_IN_WE     (accept),
        .D_IN_ADDR   (col_q[LB_ADDR_W-1:0]),
        .D_IN_WDATA  (lbb_rd),
        .D_OUT_RDATA (lba_rd)
    );

    conv_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_IMG_WIDTH),
        .ADDR_W     (LB_ADDR_W)
    ) u_lb_b (
        .C_IN_CLK    (C_IN_CLK),
        .C_IN_WE     (accept),
        .D_IN_ADDR   (col_q[LB_ADDR_W-1:0]),
        .D_IN_WDATA  (D_IN_DATA),
        .D_OUT_RDATA (lbb_rd)
    );

    always_ff @(posedge C_IN_CLK or posedge C_IN_RST) begin
        if (C_IN_RST)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // START overrides everything, including an in-flight frame
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_RUN:  if (accept && last_pix) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (C_IN_START)
            state_d = start_ok ? ST_RUN : ST_IDLE;
    end

    always_ff @(posedge C_IN_CLK or posedge C_IN_RST) begin
        if (C_IN_RST) begin
            w_q     <= '0;
            h_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < WIN_N; i++)
                win_q[i] <= '0;
        end else begin
            valid_q <= 1'b0;
            if (C_IN_START) begin
                err_q <= !start_ok;
                row_q <= '0;
                col_q <= '0;
                if (start_ok) begin
                    w_q <= D_IN_IMG_WIDTH;
                    h_q <= D_IN_IMG_HEIGHT;
                end
            end else if (accept) begin
                win_q[WIN_1] <= win_q[WIN_2];
                win_q[WIN_2] <= win_q[WIN_3];
                win_q[WIN_3] <= lba_rd;
                win_q[WIN_4] <= win_q[WIN_5];
                win_q[WIN_5] <= win_q[WIN_6];
                win_q[WIN_6] <= lbb_rd;
                win_q[WIN_7] <= win_q[WIN_8];
                win_q[WIN_8] <= win_q[WIN_9];
                win_q[WIN_9] <= D_IN_DATA;
                valid_q <= (row_q >= 2) && (col_q >= 2);
                if (last_col) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    assign C_OUT_DATA_VALID = valid_q;
    assign C_OUT_BUSY       = (state_q == ST_RUN);
    assign C_OUT_FRAME_DONE = (state_q == ST_DONE);
    assign C_OUT_CFG_ERR    = err_q;

    assign D_OUT_WIN_1 = win_q[WIN_1];
    assign D_OUT_WIN_2 = win_q[WIN_2];
    assign D_OUT_WIN_3 = win_q[WIN_3];
    assign D_OUT_WIN_4 = win_q[WIN_4];
    assign D_OUT_WIN_5 = win_q[WIN_5];
    assign D_OUT_WIN_6 = win_q[WIN_6];
    assign D_OUT_WIN_7 = win_q[WIN_7];
    assign D_OUT_WIN_8 = win_q[WIN_8];
    assign D_OUT_WIN_9 = win_q[WIN_9];

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: image model feeds a window scoreboard.
module tb_conv_window_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  iw, ih;
    logic        dv;
    logic [31:0] din;
    logic        vld, busy, fdone, cerr;
    logic [31:0] wo [9];

    typedef struct {
        logic [31:0] win [9];
        bit          last;
        int          cyc;
    } exp_t;

    typedef struct {
        int w;
        int h;
        bit gap;
        int restart;
        int base;
        int nwin;
    } vec_t;

    exp_t        q [$];
    exp_t        e;
    vec_t        vec [4];
    logic [31:0] img [8][64];
    int          ntest = 0;
    int          nfail = 0;
    int          cyc_n = 0;
    int          popped = 0;
    int          ndone = 0;
    bit          gap_mode = 0;
    bit          prev_v = 0;
    bit          bad;

    conv_window_gen dut (
        .C_IN_CLK         (clk),
        .C_IN_RST         (rst),
        .C_IN_START       (start),
        .D_IN_IMG_WIDTH   (iw),
        .D_IN_IMG_HEIGHT  (ih),
        .C_IN_DATA_VALID  (dv),
        .D_IN_DATA        (din),
        .C_OUT_DATA_VALID (vld),
        .D_OUT_WIN_1      (wo[0]),
        .D_OUT_WIN_2      (wo[1]),
        .D_OUT_WIN_3      (wo[2]),
        .D_OUT_WIN_4      (wo[3]),
        .D_OUT_WIN_5      (wo[4]),
        .D_OUT_WIN_6      (wo[5]),
        .D_OUT_WIN_7      (wo[6]),
        .D_OUT_WIN_8      (wo[7]),
        .D_OUT_WIN_9      (wo[8]),
        .C_OUT_BUSY       (busy),
        .C_OUT_FRAME_DONE (fdone),
        .C_OUT_CFG_ERR    (cerr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n++;

    always @(negedge clk) begin
        if (!rst) begin
            if (vld) begin
                ntest++;
                if (q.size() == 0) begin
                    nfail++;
                    $display("FAIL unexpected_window got valid=1 want valid=0");
                end else begin
                    e = q.pop_front();
                    popped++;
                    bad = 0;
                    for (int k = 0; k < 9; k++)
                        if (wo[k] !== e.win[k]) bad = 1;
                    if (bad) begin
                        nfail++;
                        $display("FAIL window got %0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d",
                                 wo[0], wo[1], wo[2], wo[3], wo[4], wo[5], wo[6], wo[7], wo[8],
                                 e.win[0], e.win[1], e.win[2], e.win[3], e.win[4],
                                 e.win[5], e.win[6], e.win[7], e.win[8]);
                    end
                    ntest++;
                    if (fdone !== e.last) begin
                        nfail++;
                        $display("FAIL frame_done_with_window got %b want %b", fdone, e.last);
                    end
                    ntest++;
                    if (cyc_n != e.cyc) begin
                        nfail++;
                        $display("FAIL latency got cycle %0d want %0d", cyc_n, e.cyc);
                    end
                end
            end
            if (fdone) begin
                ndone++;
                ntest++;
                if (!vld) begin
                    nfail++;
                    $display("FAIL frame_done_alone got valid=%b want 1", vld);
                end
            end
            if (gap_mode && vld) begin
                ntest++;
                if (prev_v) begin
                    nfail++;
                    $display("FAIL gap_back_to_back got 2 valid cycles want 1");
                end
            end
            prev_v = vld;
        end else begin
            prev_v = 0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntest++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic do_start(input int w, input int h);
        start = 1'b1;
        iw    = 8'(w);
        ih    = 8'(h);
        cyc();
        start = 1'b0;
    endtask

    task automatic send_pix(input int r, input int c, input logic [31:0] val,
                            input bit push, input int w, input int h);
        exp_t x;
        img[r][c] = val;
        din = val;
        dv  = 1'b1;
        if (push && r >= 2 && c >= 2) begin
            for (int k = 0; k < 9; k++)
                x.win[k] = img[r - 2 + k / 3][c - 2 + k % 3];
            x.last = (r == h - 1) && (c == w - 1);
            x.cyc  = cyc_n + 1;
            q.push_back(x);
        end
        cyc();
        dv  = 1'b0;
        din = '0;
    endtask

    task automatic run_frame(input vec_t v);
        gap_mode = v.gap;
        popped   = 0;
        ndone    = 0;
        if (v.restart > 0) begin
            do_start(v.w, v.h);
            for (int i = 0; i < v.restart; i++)
                send_pix(i / v.w, i % v.w, 32'(500 + i), 1, v.w, v.h);
        end
        do_start(v.w, v.h);
        chk("busy_after_start", {31'd0, busy}, 1);
        chk("cfg_err_good", {31'd0, cerr}, 0);
        for (int i = 0; i < v.w * v.h; i++) begin
            send_pix(i / v.w, i % v.w, 32'(v.base + i), 1, v.w, v.h);
            if (v.gap) cyc();
        end
        repeat (3) cyc();
        chk("windows_per_frame", popped, v.nwin);
        chk("frame_done_count", ndone, 1);
        chk("busy_after_frame", {31'd0, busy}, 0);
        chk("queue_drained", q.size(), 0);
        gap_mode = 0;
    endtask

    initial begin
        vec[0] = '{w: 4,  h: 4, gap: 0, restart: 0, base: 1, nwin: 4};
        vec[1] = '{w: 4,  h: 4, gap: 1, restart: 0, base: 1, nwin: 4};
        vec[2] = '{w: 64, h: 3, gap: 0, restart: 0, base: 0, nwin: 62};
        vec[3] = '{w: 5,  h: 5, gap: 0, restart: 8, base: 1, nwin: 9};

        rst = 1'b1; start = 1'b0; iw = '0; ih = '0; dv = 1'b0; din = '0;
        #1;
        chk("rst_valid", {31'd0, vld}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, fdone}, 0);
        chk("rst_cfg_err", {31'd0, cerr}, 0);
        chk("rst_win5", wo[4], 0);
        cyc();
        rst = 1'b0;
        cyc();

        for (int t = 0; t < 4; t++)
            run_frame(vec[t]);

        do_start(2, 5);
        chk("bad_cfg_err", {31'd0, cerr}, 1);
        chk("bad_busy", {31'd0, busy}, 0);
        for (int i = 0; i < 10; i++)
            send_pix(i / 2, i % 2, 32'(900 + i), 0, 2, 5);
        chk("bad_no_windows", q.size(), 0);
        do_start(3, 70);
        chk("bad_h_ok_cfg_err", {31'd0, cerr}, 0);
        do_start(65, 3);
        chk("w_too_big_cfg_err", {31'd0, cerr}, 1);
        run_frame('{w: 3, h: 3, gap: 0, restart: 0, base: 1, nwin: 1});

        do_start(5, 5);
        for (int i = 0; i < 13; i++)
            send_pix(i / 5, i % 5, 32'(700 + i), 1, 5, 5);
        chk("pre_reset_valid", {31'd0, vld}, 1);
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, vld}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_done", {31'd0, fdone}, 0);
        chk("arst_win1", wo[0], 0);
        chk("arst_win9", wo[8], 0);
        q.delete();
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 12; i++)
            send_pix(i / 4, i % 4, 32'(800 + i), 0, 4, 3);
        repeat (2) cyc();
        chk("post_reset_busy", {31'd0, busy}, 0);
        chk("post_reset_idle_queue", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
